up_counter_5b: RTL and testbench

- Free-running binary up-counter, 5 bits by default; increments once per clock while enabled and wraps 31 -> 0.
- Used as a small timebase/sequence generator and as a pre/post-route equivalence test vehicle.
- Gate-level and RTL versions must be cycle-identical at the `out` port.

---
 rtl/up_counter_pkg.sv | 13 +
 rtl/up_counter_5b.sv | 60 ++++++
 tb/tb_up_counter_5b.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/up_counter_pkg.sv
// Shared width defaults and helpers for the up_counter_5b counter.
package up_counter_pkg;

    localparam int CNT_W_DEFAULT = 5;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    // All-ones value of a counter that is `width` bits wide.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/up_counter_5b.sv
// Free-running up-counter with synchronous load, terminal count and wrap pulse.
// Optional saturating mode is enabled by defining UP_COUNTER_5B_SAT_EN.
module up_counter_5b
    import up_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UP_COUNTER_5B_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             at_max;
    logic             hold_at_max;

    assign at_max = (out == MAX_VAL);

`ifdef UP_COUNTER_5B_SAT_EN
    assign hold_at_max = sat_mode & at_max;
`else
    assign hold_at_max = 1'b0;
`endif

    // Load beats increment; a saturated counter neither advances nor pulses wrap.
    always_comb begin
        cnt_nxt  = out;
        wrap_nxt = 1'b0;
        if (load) begin
            cnt_nxt = load_val;
        end else if (en && !hold_at_max) begin
            cnt_nxt  = out + WIDTH'(1);
            wrap_nxt = at_max;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign tc = &out;

endmodule

// File: tb/tb_up_counter_5b.sv
// Scoreboard bench for up_counter_5b: a reference model pushes expected outputs, checks pop them.
module tb_up_counter_5b;

    localparam int W = 5;

    typedef struct {
        string          tag;
        logic [W-1:0]   out;
        logic           wrap;
        logic           tc;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc;
    logic         wrap;
`ifdef UP_COUNTER_5B_SAT_EN
    logic         sat_mode;
`endif

    exp_t         sb_q[$];
    int           n_cmp;
    int           n_err;

    logic [W-1:0] m_out;
    logic         m_wrap;
    logic         m_sat;

    up_counter_5b #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .load_val (load_val),
`ifdef UP_COUNTER_5B_SAT_EN
        .sat_mode (sat_mode),
`endif
        .out      (out),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag  = tag;
        e.out  = m_out;
        e.wrap = m_wrap;
        e.tc   = (m_out == {W{1'b1}});
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".out"},  32'(out),  32'(e.out));
            check({e.tag, ".wrap"}, 32'(wrap), 32'(e.wrap));
            check({e.tag, ".tc"},   32'(tc),   32'(e.tc));
        end
    endtask

    // Reference behaviour for one rising edge with the given inputs.
    task automatic model_edge(input logic r, input logic e, input logic l, input logic [W-1:0] lv);
        if (!r) begin
            m_out  = '0;
            m_wrap = 1'b0;
        end else if (l) begin
            m_out  = lv;
            m_wrap = 1'b0;
        end else if (e && !(m_sat && m_out == {W{1'b1}})) begin
            m_wrap = (m_out == {W{1'b1}});
            m_out  = m_out + 1'b1;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic l, input logic [W-1:0] lv);
        @(negedge clk);
        reset    = r;
        en       = e;
        load     = l;
        load_val = lv;
        model_edge(r, e, l, lv);
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge clk);
        #2;
        reset  = 1'b0;
        m_out  = '0;
        m_wrap = 1'b0;
        push_exp(tag);
        #1;
        pop_check();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_out    = '0;
        m_wrap   = 1'b0;
        m_sat    = 1'b0;
        reset    = 1'b0;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;
`ifdef UP_COUNTER_5B_SAT_EN
        sat_mode = 1'b0;
`endif

        // Reset held for two edges with enable and load active: both ignored.
        step("rst_hold0", 1'b0, 1'b1, 1'b0, 5'd0);
        step("rst_hold1", 1'b0, 1'b1, 1'b1, 5'd21);

        // Free run from release: 1,2,...,31, then 0 with wrap, then 1.
        for (int i = 1; i <= 33; i++)
            step($sformatf("run%0d", i), 1'b1, 1'b1, 1'b0, 5'd0);

        // Count to 17, then assert reset between edges.
        while (m_out != 5'd17)
            step("to17", 1'b1, 1'b1, 1'b0, 5'd0);
        async_reset_check("async_rst");
        for (int i = 0; i < 5; i++)
            step($sformatf("rst_mid%0d", i), 1'b0, 1'b1, i[0], 5'd13);
        step("rel_first", 1'b1, 1'b1, 1'b0, 5'd0);

        // Enable gating at 9.
        while (m_out != 5'd9)
            step("to9", 1'b1, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 4; i++)
            step($sformatf("en_off%0d", i), 1'b1, 1'b0, 1'b0, 5'd0);
        step("en_back", 1'b1, 1'b1, 1'b0, 5'd0);

        // Load priority and the wrap-versus-load collision.
        step("load31",      1'b1, 1'b1, 1'b1, 5'd31);
        step("wrap_after",  1'b1, 1'b1, 1'b0, 5'd0);
        step("load31b",     1'b1, 1'b0, 1'b1, 5'd31);
        step("load_at_max", 1'b1, 1'b1, 1'b1, 5'd4);
        step("after_load4", 1'b1, 1'b1, 1'b0, 5'd0);

        // Mixed random traffic.
        for (int i = 0; i < 60; i++)
            step($sformatf("rnd%0d", i), 1'b1, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));

        // Free run, reset pulse of five cycles, free run again.
        for (int i = 0; i < 50; i++)
            step($sformatf("eq_a%0d", i), 1'b1, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++)
            step($sformatf("eq_r%0d", i), 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 50; i++)
            step($sformatf("eq_b%0d", i), 1'b1, 1'b1, 1'b0, 5'd0);

`ifdef UP_COUNTER_5B_SAT_EN
        sat_mode = 1'b1;
        m_sat    = 1'b1;
        while (m_out != 5'd31)
            step("sat_to31", 1'b1, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++)
            step($sformatf("sat_hold%0d", i), 1'b1, 1'b1, 1'b0, 5'd0);
        step("sat_load", 1'b1, 1'b1, 1'b1, 5'd6);
        sat_mode = 1'b0;
        m_sat    = 1'b0;
        step("sat_off", 1'b1, 1'b1, 1'b0, 5'd0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
